// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: divides clk into physics steps, runs the
// IDLE/SERVE/PLAY/OVER flow, keeps both scores and issues the step and
// ball_reset pulses that drive the ball/paddle datapath.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   ena          design enable; 0 freezes state, clears step/ball_reset
//   start        start/restart request, acted on at its rising edge
//   miss_left    ball passed left paddle
//   miss_right   ball passed right paddle
//   step         one-cycle pulse: advance ball/paddles one step
//   ball_reset   one-cycle pulse: recentre ball, load serve velocity
//   serve_dir    serve direction, 0 = toward left, 1 = toward right
//   score_left   left player score
//   score_right  right player score
//   state        0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
module pong_game_ctrl #(
    parameter int unsigned FRAME_DIV   = 16,
    parameter int unsigned SERVE_STEPS = 8,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               step,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         state
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(SERVE_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_q_d;
    logic [SCORE_W-1:0] sl_d, sr_d;
    logic               dir_d, step_d, br_d;

    logic start_rise_c;
    logic tick_c;
    logic any_miss_c;

    assign start_rise_c = start & ~start_q;
    assign tick_c       = (div_q == DIV_W'(FRAME_DIV - 1));
    assign any_miss_c   = miss_left | miss_right;
    assign state        = state_q;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b1;
            step        <= 1'b0;
            ball_reset  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            start_q     <= start_q_d;
            score_left  <= sl_d;
            score_right <= sr_d;
            serve_dir   <= dir_d;
            step        <= step_d;
            ball_reset  <= br_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        start_q_d = start_q;
        sl_d      = score_left;
        sr_d      = score_right;
        dir_d     = serve_dir;
        step_d    = 1'b0;
        br_d      = 1'b0;

        if (ena) begin
            start_q_d = start;
            div_d     = tick_c ? '0 : div_q + DIV_W'(1);

            unique case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_rise_c) begin
                        state_d = S_SERVE;
                        sl_d    = '0;
                        sr_d    = '0;
                        dir_d   = 1'b1;
                        cnt_d   = '0;
                        br_d    = 1'b1;
                    end
                end
                S_SERVE: begin
                    if (tick_c) begin
                        if (cnt_q == CNT_W'(SERVE_STEPS - 1)) begin
                            state_d = S_PLAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_PLAY: begin
                    // A miss outranks the tick: no step, recentre instead
                    if (any_miss_c) begin
                        if (miss_left) sr_d = score_right + SCORE_W'(1);
                        if (miss_right) sl_d = score_left + SCORE_W'(1);
                        if (miss_left && !miss_right) dir_d = 1'b0;
                        if (miss_right && !miss_left) dir_d = 1'b1;
                        br_d  = 1'b1;
                        cnt_d = '0;
                        if (sl_d == SCORE_W'(WIN_SCORE) || sr_d == SCORE_W'(WIN_SCORE)) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end else begin
                        step_d = tick_c;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    localparam int unsigned FD = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned WS = 5;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic          miss_left;
    logic          miss_right;
    logic          step;
    logic          ball_reset;
    logic          serve_dir;
    logic [SW-1:0] score_left;
    logic [SW-1:0] score_right;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;
    int div_m    = 0;

    pong_game_ctrl #(
        .FRAME_DIV  (FD),
        .SERVE_STEPS(SS),
        .WIN_SCORE  (WS),
        .SCORE_W    (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .step       (step),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // One clock; the bench tracks the divider to predict ticks
    task automatic cyc();
        @(posedge clk);
        if (rst_n && ena) div_m = (div_m == int'(FD) - 1) ? 0 : div_m + 1;
        #1;
    endtask

    // Stay in SERVE until SS ticks have passed, then expect PLAY
    task automatic wait_play(input int t0);
        int t;
        t = t0;
        for (int i = 0; i < 20; i++) begin
            bit pre;
            pre = (div_m == int'(FD) - 1);
            cyc();
            if (pre) t++;
            if (t >= int'(SS)) begin
                chk("enter_play", 32'(state), 32'd2);
                return;
            end
            chk("serve_hold", 32'(state), 32'd1);
            chk("serve_no_step", 32'(step), 32'd0);
            chk("serve_no_br", 32'(ball_reset), 32'd0);
        end
        chk("play_timeout", 32'(state), 32'd2);
    endtask

    // In PLAY: step must follow each predicted tick, and only then
    task automatic play_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bit pre;
            pre = (div_m == int'(FD) - 1);
            cyc();
            chk("play_step", 32'(step), 32'(pre));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; ena = 1'b1; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sl", 32'(score_left), 32'd0);
        chk("rst_sr", 32'(score_right), 32'd0);
        chk("rst_dir", 32'(serve_dir), 32'd1);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_br", 32'(ball_reset), 32'd0);
        #9 rst_n = 1'b1;
        div_m = 0;
        repeat (2) begin
            cyc();
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_step", 32'(step), 32'd0);
            chk("idle_br", 32'(ball_reset), 32'd0);
        end

        // Start: one ball_reset pulse, SERVE, then PLAY after SS ticks
        start = 1'b1;
        cyc();
        chk("start_br", 32'(ball_reset), 32'd1);
        chk("start_state", 32'(state), 32'd1);
        chk("start_dir", 32'(serve_dir), 32'd1);
        chk("start_sl", 32'(score_left), 32'd0);
        start = 1'b0;
        wait_play(0);
        play_steps(9);

        // start during PLAY is ignored
        start = 1'b1;
        cyc();
        chk("play_start_ign", 32'(state), 32'd2);
        start = 1'b0;

        // miss_right on a tick cycle
        while (div_m != int'(FD) - 1) cyc();
        miss_right = 1'b1;
        cyc();
        miss_right = 1'b0;
        chk("mr_step", 32'(step), 32'd0);
        chk("mr_sl", 32'(score_left), 32'd1);
        chk("mr_dir", 32'(serve_dir), 32'd1);
        chk("mr_br", 32'(ball_reset), 32'd1);
        chk("mr_state", 32'(state), 32'd1);

        // miss_left during SERVE is ignored
        begin
            bit pre;
            pre = (div_m == int'(FD) - 1);
            miss_left = 1'b1;
            cyc();
            miss_left = 1'b0;
            chk("serve_miss_sr", 32'(score_right), 32'd0);
            chk("serve_miss_br", 32'(ball_reset), 32'd0);
            chk("serve_miss_state", 32'(state), 32'd1);
            wait_play(pre ? 1 : 0);
        end

        // miss_left in PLAY
        miss_left = 1'b1;
        cyc();
        miss_left = 1'b0;
        chk("ml_sr", 32'(score_right), 32'd1);
        chk("ml_dir", 32'(serve_dir), 32'd0);
        chk("ml_br", 32'(ball_reset), 32'd1);
        chk("ml_step", 32'(step), 32'd0);
        chk("ml_state", 32'(state), 32'd1);
        wait_play(0);

        // ena=0 freezes everything; step timing resumes from frozen divider
        play_steps(2);
        ena = 1'b0;
        repeat (10) begin
            cyc();
            chk("frz_step", 32'(step), 32'd0);
            chk("frz_state", 32'(state), 32'd2);
        end
        chk("frz_sl", 32'(score_left), 32'd1);
        chk("frz_sr", 32'(score_right), 32'd1);
        ena = 1'b1;
        play_steps(8);

        // Build scores up to 4-4
        repeat (3) begin
            miss_right = 1'b1;
            cyc();
            miss_right = 1'b0;
            wait_play(0);
        end
        repeat (3) begin
            miss_left = 1'b1;
            cyc();
            miss_left = 1'b0;
            wait_play(0);
        end
        chk("pre_sl", 32'(score_left), 32'd4);
        chk("pre_sr", 32'(score_right), 32'd4);
        chk("pre_dir", 32'(serve_dir), 32'd0);

        // Double miss ends the game; start held across entry does nothing
        miss_left = 1'b1; miss_right = 1'b1; start = 1'b1;
        cyc();
        miss_left = 1'b0; miss_right = 1'b0;
        chk("win_sl", 32'(score_left), 32'd5);
        chk("win_sr", 32'(score_right), 32'd5);
        chk("win_dir", 32'(serve_dir), 32'd0);
        chk("win_state", 32'(state), 32'd3);
        chk("win_br", 32'(ball_reset), 32'd1);
        repeat (3) begin
            cyc();
            chk("over_hold", 32'(state), 32'd3);
        end
        miss_left = 1'b1;
        cyc();
        miss_left = 1'b0;
        chk("over_miss_sr", 32'(score_right), 32'd5);
        chk("over_miss_br", 32'(ball_reset), 32'd0);
        start = 1'b0;
        cyc();
        chk("over_low", 32'(state), 32'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_sl", 32'(score_left), 32'd0);
        chk("restart_sr", 32'(score_right), 32'd0);
        chk("restart_dir", 32'(serve_dir), 32'd1);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_br", 32'(ball_reset), 32'd1);
        wait_play(0);

        // Asynchronous reset mid-PLAY
        play_steps(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_sl", 32'(score_left), 32'd0);
        chk("arst_dir", 32'(serve_dir), 32'd1);
        chk("arst_step", 32'(step), 32'd0);
        chk("arst_br", 32'(ball_reset), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        div_m = 0;
        repeat (6) begin
            cyc();
            chk("rel_step", 32'(step), 32'd0);
            chk("rel_br", 32'(ball_reset), 32'd0);
            chk("rel_state", 32'(state), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the pong datapath. It divides the system clock into physics steps, runs the serve/play/point/game-over flow, keeps both players' scores, and issues the step and ball-recentre pulses that advance and reset the ball/paddle datapath. It sits between the top-level ui_in controls and the pong physics registers.

Parameters:
FRAME_DIV, 16, clock cycles per physics step (>=2)
SERVE_STEPS, 8, physics ticks of pause in SERVE before play resumes (>=1)
WIN_SCORE, 5, score that ends the game (1..2^SCORE_W-1)
SCORE_W, 4, score counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; 0 freezes all state
start  input  1  start/restart request, acted on at its rising edge only
miss_left  input  1  datapath flag: ball passed left paddle
miss_right  input  1  datapath flag: ball passed right paddle
step  output  1  one-cycle pulse: advance ball/paddles one step
ball_reset  output  1  one-cycle pulse: recentre ball, load serve velocity
serve_dir  output  1  serve direction, 0 = toward left, 1 = toward right
score_left  output  SCORE_W  left player score
score_right  output  SCORE_W  right player score
state  output  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER

Behaviour:
- Reset (rst_n=0, async): state=IDLE, scores=0, step=0, ball_reset=0, serve_dir=1, divider=0, serve count=0, start_q=0.
- All outputs registered. With ena=0, every register holds its value except step and ball_reset, which clear to 0 on the next edge.
- start_q holds the previous start value. start_rise = start & ~start_q.
- Divider counts 0..FRAME_DIV-1 in every state and wraps. tick = (divider==FRAME_DIV-1).
- IDLE: on start_rise go to SERVE. Scores clear to 0, serve_dir=1, serve count=0, ball_reset=1 for one cycle. The divider is not reset.
- SERVE: step stays 0. On each tick, serve count increments. The tick that brings the count to SERVE_STEPS moves the FSM to PLAY and clears the count. Misses are ignored in SERVE.
- PLAY: step is registered as tick & no miss this cycle. In steady play, step fires exactly once every FRAME_DIV cycles, one cycle after divider==FRAME_DIV-1.
- Misses in PLAY:
  - miss_left: score_right+1, serve_dir=0.
  - miss_right: score_left+1, serve_dir=1.
  - Both in the same cycle: both scores increment and serve_dir holds.
  - Any miss pulses ball_reset for one cycle and suppresses step that cycle.
  - Next state is OVER if either updated score equals WIN_SCORE, else SERVE (serve count=0).
  - Misses take priority over tick.
- Score arithmetic: unsigned SCORE_W bits. A score never exceeds WIN_SCORE, because the game stops there.
- OVER: scores, state and serve_dir are frozen and misses are ignored. start_rise behaves exactly as in IDLE. A start held high across OVER entry does not restart the game.
- start_rise during SERVE/PLAY is ignored.
- Mid-operation rst_n assertion immediately forces the reset values. No step or ball_reset pulse is emitted on reset release.

Test Plan:
1. Assert rst_n=0 mid-PLAY with FRAME_DIV=4 -> outputs go asynchronously to state=0, scores=0, serve_dir=1, step=0, ball_reset=0. No pulse on release.
2. FRAME_DIV=4, SERVE_STEPS=2, ena=1, start rising at cycle t -> ball_reset=1 at t+1 only and state=1. State=2 after the 2nd tick. step is then high every 4th cycle, never two consecutive cycles.
3. In PLAY, pulse miss_right on a tick cycle -> no step that cycle, score_left=1, serve_dir=1, ball_reset one-cycle pulse, state=1. Later miss_left -> score_right=1, serve_dir=0.
4. WIN_SCORE=5, scores at 4-4, miss_left and miss_right in the same cycle -> both scores 5, serve_dir unchanged, state=3. Holding start high -> stays in OVER. A new start rising edge -> scores 0, serve_dir=1, state=1.
5. In PLAY, ena=0 for 10 cycles -> step=0 throughout, and divider, state and scores are frozen. After ena=1, the next step arrives after the remaining divider count.
6. miss_left asserted during SERVE and during OVER -> no score change, no ball_reset.
